serv_fetch_seq: RTL and testbench
=================================

Name: serv_fetch_seq

Overview:
- Sequencer for the bit-serial PC/control datapath.
- Runs the per-instruction cycle: instruction fetch handshake, register-file read request, optional init pass, optional data-bus wait, then the execute pass.
- During the passes it generates the beat-position strobes (cnt0/cnt1/cnt2/cnt03/cnt12to31), the PC shift enable and the one-cycle PC-load reset pulse consumed by the control datapath.

Parameters:
- W, 1, datapath width per beat; legal values 1 or 4. A pass is 32/W beats.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- o_ctrl_rst  out  1  one-cycle pulse after reset release; loads RESET_PC into control datapath
- o_ibus_cyc  out  1  instruction fetch request
- i_ibus_ack  in  1  fetch complete; instruction/decode valid this cycle
- i_two_stage  in  1  decoded instruction needs init pass (branch, shift, load/store, slt)
- i_mem_op  in  1  decoded instruction is load/store
- o_rf_rreq  out  1  register-file read request pulse
- i_rf_ready  in  1  register-file operands streaming from next cycle
- o_dbus_cyc  out  1  data bus request
- i_dbus_ack  in  1  data bus transfer complete
- o_init  out  1  init pass active
- o_pc_en  out  1  execute pass active; PC shifts
- o_cnt0  out  1  beat containing bit 0
- o_cnt1  out  1  beat containing bit 1
- o_cnt2  out  1  beat containing bit 2
- o_cnt03  out  1  beat contains any of bits 0..3
- o_cnt12to31  out  1  beat contains bits >= 12
- o_cnt_done  out  1  last beat of a pass

Behaviour:
- States: RST, FETCH, RFREQ, RFWAIT, INIT, MEMWAIT, RUN. Beat counter b has width log2(32/W) (5 bits for W=1, 3 bits for W=4).
- Reset (async, i_rst_n=0):
  - state=RST, b=0, all outputs 0 immediately.
  - This applies mid-fetch or mid-pass too: an outstanding o_ibus_cyc/o_dbus_cyc drops at once, and no ack is honoured until FETCH is re-entered.
- RST (first clock edge after release): o_ctrl_rst=1 for exactly one cycle; next state FETCH.
- FETCH:
  - o_ibus_cyc=1, held until i_ibus_ack.
  - On ack, i_two_stage/i_mem_op are sampled into registers; next state RFREQ.
  - Ack in the same cycle as cyc first rises is legal.
- RFREQ: o_rf_rreq=1 for one cycle; next RFWAIT.
- RFWAIT: wait for i_rf_ready. On ready: go to INIT if latched two_stage, else RUN. b=0 on entry.
- INIT:
  - o_init=1; b increments every cycle; strobes active.
  - At b=32/W-1 (o_cnt_done=1): go to MEMWAIT if latched mem_op, else RUN. b wraps to 0.
- MEMWAIT:
  - o_dbus_cyc=1 until i_dbus_ack.
  - On ack go to RUN; b=0. Ack with cyc first rising is legal.
- RUN:
  - o_pc_en=1; b increments; strobes active.
  - At last beat (o_cnt_done=1): next FETCH, b=0.
  - No idle cycle between RUN end and o_ibus_cyc.
- Strobes are 0 outside INIT/RUN. Within a pass:
  - W=1: cnt0 = b==0; cnt1 = b==1; cnt2 = b==2; cnt03 = b<4; cnt12to31 = b>=12.
  - W=4: cnt0 = cnt1 = cnt2 = cnt03 = b==0; cnt12to31 = b>=3.
  - cnt_done = b==32/W-1.
- Timing: all outputs are registered-state decodes (Moore); no combinational path from any input to any output.
- Pass length: INIT and RUN each last exactly 32/W cycles.
- Minimum instruction latency (single-stage, zero-wait acks) = 1 (FETCH) + 1 (RFREQ) + 1 (RFWAIT) + 32/W (RUN) cycles.
- Spurious acks: i_ibus_ack outside FETCH and i_dbus_ack outside MEMWAIT are ignored. i_rf_ready outside RFWAIT is ignored.
- Illegal W: elaboration error.

Test Plan:
- Reset release, W=1: deassert i_rst_n -> o_ctrl_rst high exactly 1 cycle, then o_ibus_cyc=1 next cycle; all other outputs 0.
- Single-stage instruction, W=1, ack after 3 wait cycles, rf_ready 2 cycles after rreq:
  - o_pc_en high exactly 32 cycles.
  - o_cnt03 on first 4 beats; o_cnt12to31 on last 20 beats; o_cnt_done on beat 31.
  - o_ibus_cyc rises the cycle after cnt_done.
- Load instruction, W=4, two_stage=1, mem_op=1, dbus ack after 5 cycles:
  - o_init 8 cycles, then o_dbus_cyc 6 cycles, then o_pc_en 8 cycles.
  - cnt0/cnt1/cnt2/cnt03 on beat 0 only; cnt12to31 on beats 3..7.
- Zero-wait back-to-back single-stage, W=4 -> instruction period = 11 cycles; o_rf_rreq pulses once per instruction.
- Async reset asserted mid-RUN at beat 17 (W=1) -> o_pc_en and strobes drop without a clock edge; after release, RST pulse, then FETCH with b restarting at 0.
- Spurious i_dbus_ack during RUN and i_ibus_ack during INIT -> no state change; pass lengths unchanged (32 beats for W=1).

Source files
------------

// File: rtl/serv_fetch_seq.sv
// rtl/serv_fetch_seq.sv - per-instruction sequencer for the bit-serial PC/control datapath
// Moore FSM: fetch, rf read, optional init pass, optional dbus wait, execute pass.
module serv_fetch_seq #(
  parameter int W = 1
) (
  input  logic clk,
  input  logic i_rst_n,
  output logic o_ctrl_rst,
  output logic o_ibus_cyc,
  input  logic i_ibus_ack,
  input  logic i_two_stage,
  input  logic i_mem_op,
  output logic o_rf_rreq,
  input  logic i_rf_ready,
  output logic o_dbus_cyc,
  input  logic i_dbus_ack,
  output logic o_init,
  output logic o_pc_en,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt2,
  output logic o_cnt03,
  output logic o_cnt12to31,
  output logic o_cnt_done
);

  localparam int BEATS = 32 / W;
  localparam int BW    = (W == 1) ? 5 : 3;

  // Beat indices for each strobe; with W=4 bits 0..3 all share beat 0
  localparam logic [BW-1:0] B_LAST = BW'(BEATS - 1);
  localparam logic [BW-1:0] B_ONE  = BW'((W == 1) ? 1 : 0);
  localparam logic [BW-1:0] B_TWO  = BW'((W == 1) ? 2 : 0);
  localparam logic [BW-1:0] B_LT4  = BW'((W == 1) ? 4 : 1);
  localparam logic [BW-1:0] B_HI   = BW'((W == 1) ? 12 : 3);

  generate
    if (!(W == 1 || W == 4)) begin : g_bad_w
      $error("serv_fetch_seq: W must be 1 or 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_RFREQ, S_RFWAIT, S_INIT, S_MEMWAIT, S_RUN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BW-1:0]   r_beat;
  logic            r_ctrl_rst;
  logic            r_two_stage;
  logic            r_mem_op;
  logic            w_pass;

  assign w_pass = (r_state == S_INIT) || (r_state == S_RUN);

  // r_ctrl_rst gives RST a second cycle so the pulse never shows while reset is held
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_RST;
      r_beat      <= '0;
      r_ctrl_rst  <= 1'b0;
      r_two_stage <= 1'b0;
      r_mem_op    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ctrl_rst <= (r_state == S_RST) && !r_ctrl_rst;
      if (r_state == S_FETCH && i_ibus_ack) begin
        r_two_stage <= i_two_stage;
        r_mem_op    <= i_mem_op;
      end
      r_beat <= w_pass ? r_beat + 1'b1 : '0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:     if (r_ctrl_rst) w_next = S_FETCH;
      S_FETCH:   if (i_ibus_ack) w_next = S_RFREQ;
      S_RFREQ:   w_next = S_RFWAIT;
      S_RFWAIT:  if (i_rf_ready) w_next = r_two_stage ? S_INIT : S_RUN;
      S_INIT:    if (r_beat == B_LAST) w_next = r_mem_op ? S_MEMWAIT : S_RUN;
      S_MEMWAIT: if (i_dbus_ack) w_next = S_RUN;
      S_RUN:     if (r_beat == B_LAST) w_next = S_FETCH;
      default:   w_next = S_RST;
    endcase
  end

  always_comb begin
    o_ctrl_rst  = r_ctrl_rst;
    o_ibus_cyc  = (r_state == S_FETCH);
    o_rf_rreq   = (r_state == S_RFREQ);
    o_dbus_cyc  = (r_state == S_MEMWAIT);
    o_init      = (r_state == S_INIT);
    o_pc_en     = (r_state == S_RUN);
    o_cnt0      = w_pass && (r_beat == '0);
    o_cnt1      = w_pass && (r_beat == B_ONE);
    o_cnt2      = w_pass && (r_beat == B_TWO);
    o_cnt03     = w_pass && (r_beat < B_LT4);
    o_cnt12to31 = w_pass && (r_beat >= B_HI);
    o_cnt_done  = w_pass && (r_beat == B_LAST);
  end

endmodule

// File: tb/tb_serv_fetch_seq.sv
// tb/tb_serv_fetch_seq.sv - randomized schedule-driven bench for serv_fetch_seq
// Index 0 is the W=1 instance, index 1 the W=4 instance.
module tb_serv_fetch_seq;

  localparam int P_RST = 0, P_FETCH = 1, P_RFREQ = 2, P_RFWAIT = 3;
  localparam int P_INIT = 4, P_MEM = 5, P_RUN = 6;

  typedef struct {
    int ph;
    int k;
    logic ia, rr, da, ts, mo;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] ia = '0, ts = '0, mo = '0, rr = '0, da = '0;
  logic [1:0] ctrl_rst, ibus_cyc, rf_rreq, dbus_cyc, init, pc_en;
  logic [1:0] cnt0, cnt1, cnt2, cnt03, cnt12, cnt_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   sel      = 0;
  bit   noise    = 1'b0;
  int   pc_seen, rreq_seen, exp_run, exp_rreq;
  rec_t q[$];

  always #5 clk = ~clk;

  serv_fetch_seq #(.W(1)) u_dut1 (
    .clk(clk), .i_rst_n(rst_n), .o_ctrl_rst(ctrl_rst[0]), .o_ibus_cyc(ibus_cyc[0]),
    .i_ibus_ack(ia[0]), .i_two_stage(ts[0]), .i_mem_op(mo[0]), .o_rf_rreq(rf_rreq[0]),
    .i_rf_ready(rr[0]), .o_dbus_cyc(dbus_cyc[0]), .i_dbus_ack(da[0]), .o_init(init[0]),
    .o_pc_en(pc_en[0]), .o_cnt0(cnt0[0]), .o_cnt1(cnt1[0]), .o_cnt2(cnt2[0]),
    .o_cnt03(cnt03[0]), .o_cnt12to31(cnt12[0]), .o_cnt_done(cnt_done[0])
  );

  serv_fetch_seq #(.W(4)) u_dut4 (
    .clk(clk), .i_rst_n(rst_n), .o_ctrl_rst(ctrl_rst[1]), .o_ibus_cyc(ibus_cyc[1]),
    .i_ibus_ack(ia[1]), .i_two_stage(ts[1]), .i_mem_op(mo[1]), .o_rf_rreq(rf_rreq[1]),
    .i_rf_ready(rr[1]), .o_dbus_cyc(dbus_cyc[1]), .i_dbus_ack(da[1]), .o_init(init[1]),
    .o_pc_en(pc_en[1]), .o_cnt0(cnt0[1]), .o_cnt1(cnt1[1]), .o_cnt2(cnt2[1]),
    .o_cnt03(cnt03[1]), .o_cnt12to31(cnt12[1]), .o_cnt_done(cnt_done[1])
  );

  function automatic logic [11:0] obs(input int s);
    return {ctrl_rst[s], ibus_cyc[s], rf_rreq[s], dbus_cyc[s], init[s], pc_en[s],
            cnt0[s], cnt1[s], cnt2[s], cnt03[s], cnt12[s], cnt_done[s]};
  endfunction

  // Strobes derived from which datapath bits the beat carries
  function automatic logic [11:0] expv(input rec_t r, input int w);
    int  lo, hi;
    bit  pass;
    lo   = r.k * w;
    hi   = lo + w - 1;
    pass = (r.ph == P_INIT) || (r.ph == P_RUN);
    return {r.ph == P_RST, r.ph == P_FETCH, r.ph == P_RFREQ, r.ph == P_MEM,
            r.ph == P_INIT, r.ph == P_RUN,
            pass && lo == 0, pass && lo <= 1 && hi >= 1, pass && lo <= 2 && hi >= 2,
            pass && lo <= 3, pass && hi >= 12, pass && r.k == 32 / w - 1};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic nz();
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic add(input int ph, input int k, input logic a_i, input logic a_r,
                     input logic a_d, input logic a_t, input logic a_m);
    rec_t r;
    r.ph = ph; r.k = k; r.ia = a_i; r.rr = a_r; r.da = a_d; r.ts = a_t; r.mo = a_m;
    q.push_back(r);
  endtask

  task automatic add_instr(input int w, input bit two, input bit mem,
                           input int aw, input int rw, input int dw);
    for (int i = 0; i <= aw; i++)
      add(P_FETCH, 0, i == aw, nz(), nz(), (i == aw) ? two : nz(), (i == aw) ? mem : nz());
    add(P_RFREQ, 0, nz(), nz(), nz(), nz(), nz());
    for (int i = 0; i <= rw; i++)
      add(P_RFWAIT, 0, nz(), i == rw, nz(), nz(), nz());
    if (two) begin
      for (int k = 0; k < 32 / w; k++) add(P_INIT, k, nz(), nz(), nz(), nz(), nz());
      if (mem)
        for (int i = 0; i <= dw; i++) add(P_MEM, 0, nz(), nz(), i == dw, nz(), nz());
    end
    for (int k = 0; k < 32 / w; k++) add(P_RUN, k, nz(), nz(), nz(), nz(), nz());
  endtask

  task automatic add_random(input int w, input int n);
    for (int i = 0; i < n; i++)
      add_instr(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 4));
  endtask

  task automatic session_start(input int s);
    sel = s;
    rst_n = 1'b0;
    ia = '0; ts = '0; mo = '0; rr = '0; da = '0;
    pc_seen = 0; rreq_seen = 0; exp_run = 0; exp_rreq = 0;
    q.delete();
    repeat (2) begin
      @(negedge clk);
      check("reset_zero", obs(sel), 12'h000);
    end
    rst_n = 1'b1;
    add(P_RST, 0, nz(), nz(), nz(), nz(), nz());
  endtask

  task automatic run_queue();
    rec_t r;
    int   w;
    w = (sel == 0) ? 1 : 4;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      check($sformatf("w%0d_ph%0d_k%0d", w, r.ph, r.k), obs(sel), expv(r, w));
      if (pc_en[sel]) pc_seen++;
      if (rf_rreq[sel]) rreq_seen++;
      if (r.ph == P_RUN) exp_run++;
      if (r.ph == P_RFREQ) exp_rreq++;
      ia[sel] = r.ia; rr[sel] = r.rr; da[sel] = r.da; ts[sel] = r.ts; mo[sel] = r.mo;
    end
    check("pc_en_cycles", 12'(pc_seen), 12'(exp_run));
    check("rreq_pulses", 12'(rreq_seen), 12'(exp_rreq));
  endtask

  initial begin
    // W=1: single-stage with waits, then noisy random mix
    session_start(0);
    noise = 1'b0;
    add_instr(1, 1'b0, 1'b0, 3, 1, 0);
    noise = 1'b1;
    add_instr(1, 1'b1, 1'b0, 0, 0, 0);
    add_random(1, 8);
    run_queue();

    // W=4: load, zero-wait back-to-back, then noisy random mix
    session_start(1);
    noise = 1'b0;
    add_instr(4, 1'b1, 1'b1, 1, 1, 5);
    repeat (3) add_instr(4, 1'b0, 1'b0, 0, 0, 0);
    noise = 1'b1;
    add_random(4, 30);
    run_queue();

    // W=1: async reset in the middle of RUN beat 17
    session_start(0);
    add_instr(1, 1'b0, 1'b0, 1, 0, 0);
    while (!(q[$].ph == P_RUN && q[$].k == 17)) void'(q.pop_back());
    run_queue();
    #2 rst_n = 1'b0;
    #1 check("async_drop", obs(0), 12'h000);

    session_start(0);
    add_random(1, 3);
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
